// File: rtl/felis_mem_pkg.sv
// Shared types and constants for the main-memory responder.
// Holds the responder FSM state encoding and the default word-address width.
package felis_mem_pkg;

    localparam int          MAIN_MEM_ADDR_WIDTH = 16;
    localparam logic [31:0] MEM_OOR_DATA        = 32'hffffffff;

    typedef enum logic [2:0] {
        IDLE,
        WRITE_DONE,
        READ_WAIT,
        READ_DONE,
        RELEASE
    } mem_resp_state_t;

endpackage

// File: rtl/main_mem_responder_if.sv
// Executor-to-memory handshake bundle: a write channel (in_*) and a read channel (out_*).
// The executor drives the master modport; the memory responder uses the slave modport.
interface main_mem_responder_if;

    logic [31:0] main_mem_in_addr;
    logic [31:0] main_mem_in_data;
    logic        main_mem_in_valid;
    logic        main_mem_in_ready;

    logic [31:0] main_mem_out_addr;
    logic        main_mem_out_valid;
    logic [31:0] main_mem_out_data;
    logic        main_mem_out_ready;

    modport master (
        output main_mem_in_addr, main_mem_in_data, main_mem_in_valid,
        output main_mem_out_addr, main_mem_out_valid,
        input  main_mem_in_ready, main_mem_out_data, main_mem_out_ready
    );

    modport slave (
        input  main_mem_in_addr, main_mem_in_data, main_mem_in_valid,
        input  main_mem_out_addr, main_mem_out_valid,
        output main_mem_in_ready, main_mem_out_data, main_mem_out_ready
    );

endinterface

// File: rtl/main_mem_bram.sv
// Single-port, write-first, registered-output word RAM, written so synthesis infers block RAM.
module main_mem_bram #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // NOTE: the array and its output register have no reset; a reset term would stop block-RAM inference.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
            dout      <= din;
        end else begin
            dout      <= mem[addr];
        end
    end

endmodule

// File: rtl/main_mem_responder.sv
// Main-memory responder: serves executor word writes/reads from one BRAM with one-cycle ready pulses.
// Define MAIN_MEM_BOUNDS_CHECK_EN to reject out-of-range addresses and raise sticky bounds_err.
module main_mem_responder
    import felis_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = MAIN_MEM_ADDR_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    main_mem_responder_if.slave  mem,
    output logic                 bounds_err
);

    mem_resp_state_t       state, state_next;
    logic                  served_wr;
    logic                  rd_oor;
    logic [31:0]           out_data_q;

    logic [ADDR_WIDTH-1:0] wr_idx, rd_idx, ram_addr;
    logic                  ram_we;
    logic [31:0]           ram_dout;
    logic                  wr_oor, rd_oor_now;

    assign wr_idx = mem.main_mem_in_addr[ADDR_WIDTH+1:2];
    assign rd_idx = mem.main_mem_out_addr[ADDR_WIDTH+1:2];

    // Byte-offset bits never select anything; words are always whole.
    logic unused_low_bits;
    assign unused_low_bits = ^{mem.main_mem_in_addr[1:0], mem.main_mem_out_addr[1:0]};

`ifdef MAIN_MEM_BOUNDS_CHECK_EN
    logic err_q;

    assign wr_oor     = (mem.main_mem_in_addr  >> (ADDR_WIDTH + 2)) != 32'd0;
    assign rd_oor_now = (mem.main_mem_out_addr >> (ADDR_WIDTH + 2)) != 32'd0;
    assign bounds_err = err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (state == IDLE) begin
            if ((mem.main_mem_in_valid && wr_oor) ||
                (!mem.main_mem_in_valid && mem.main_mem_out_valid && rd_oor_now)) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    // Upper address bits are dropped so accesses wrap modulo capacity.
    logic unused_high_bits;
    assign unused_high_bits = ^{mem.main_mem_in_addr[31:ADDR_WIDTH+2],
                                mem.main_mem_out_addr[31:ADDR_WIDTH+2]};
    assign wr_oor     = 1'b0;
    assign rd_oor_now = 1'b0;
    assign bounds_err = 1'b0;
`endif

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        ram_we     = 1'b0;
        ram_addr   = rd_idx;
        unique case (state)
            IDLE: begin
                if (mem.main_mem_in_valid) begin
                    ram_addr   = wr_idx;
                    ram_we     = !wr_oor;
                    state_next = WRITE_DONE;
                end else if (mem.main_mem_out_valid) begin
                    state_next = READ_WAIT;
                end
            end
            WRITE_DONE: state_next = RELEASE;
            READ_WAIT:  state_next = READ_DONE;
            READ_DONE:  state_next = RELEASE;
            RELEASE: begin
                // Only the channel just served can release us; the other one waits its turn.
                if (served_wr ? !mem.main_mem_in_valid : !mem.main_mem_out_valid) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            served_wr  <= 1'b0;
            rd_oor     <= 1'b0;
            out_data_q <= 32'd0;
        end else begin
            state <= state_next;
            if (state == IDLE) begin
                served_wr <= mem.main_mem_in_valid;
                rd_oor    <= rd_oor_now;
            end
            if (state == READ_WAIT) begin
                out_data_q <= rd_oor ? MEM_OOR_DATA : ram_dout;
            end
        end
    end

    main_mem_bram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (32)
    ) u_bram (
        .clk  (clk),
        .we   (ram_we && !reset),
        .addr (ram_addr),
        .din  (mem.main_mem_in_data),
        .dout (ram_dout)
    );

    assign mem.main_mem_in_ready  = (state == WRITE_DONE);
    assign mem.main_mem_out_ready = (state == READ_DONE);
    assign mem.main_mem_out_data  = out_data_q;

endmodule

// File: tb/tb_main_mem_responder.sv
// Scoreboard bench for main_mem_responder: stimulus queues expected responses with their cycle,
// a negedge monitor pops and compares whenever a ready pulse appears.
module tb_main_mem_responder;
    import felis_mem_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic bounds_err;

    main_mem_responder_if mm();

    main_mem_responder dut (
        .clk        (clk),
        .reset      (reset),
        .mem        (mm.slave),
        .bounds_err (bounds_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit          is_read;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every ready pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset && (mm.main_mem_in_ready || mm.main_mem_out_ready)) begin
            check("ready_exclusive", {31'd0, mm.main_mem_in_ready & mm.main_mem_out_ready}, 32'd0);
            if (sb_q.size() == 0) begin
                check("unexpected_ready", {30'd0, mm.main_mem_in_ready, mm.main_mem_out_ready}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("resp_kind", {31'd0, mm.main_mem_out_ready}, {31'd0, e.is_read});
                check("resp_cycle", cyc, e.cyc);
                if (e.is_read) check("read_data", mm.main_mem_out_data, e.data);
            end
        end
    end

    task automatic wait_ready(input bit is_read);
        int n = 0;
        logic rdy;
        do begin
            @(negedge clk);
            n++;
            rdy = is_read ? mm.main_mem_out_ready : mm.main_mem_in_ready;
        end while (!rdy && n < 20);
        if (!rdy) check(is_read ? "read_ready_timeout" : "write_ready_timeout", {31'd0, rdy}, 32'd1);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        sb_q.push_back('{is_read: 1'b0, data: d, cyc: cyc + 1});
        mm.main_mem_in_addr  = a;
        mm.main_mem_in_data  = d;
        mm.main_mem_in_valid = 1'b1;
        wait_ready(1'b0);
        mm.main_mem_in_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] d);
        sb_q.push_back('{is_read: 1'b1, data: d, cyc: cyc + 2});
        mm.main_mem_out_addr  = a;
        mm.main_mem_out_valid = 1'b1;
        wait_ready(1'b1);
        mm.main_mem_out_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        mm.main_mem_in_addr   = 32'd0;
        mm.main_mem_in_data   = 32'd0;
        mm.main_mem_in_valid  = 1'b0;
        mm.main_mem_out_addr  = 32'd0;
        mm.main_mem_out_valid = 1'b0;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_in_ready",  {31'd0, mm.main_mem_in_ready},  32'd0);
        check("rst_out_ready", {31'd0, mm.main_mem_out_ready}, 32'd0);
        check("rst_out_data",  mm.main_mem_out_data,           32'd0);
        check("rst_bounds_err", {31'd0, bounds_err},           32'd0);
        @(negedge clk);

        // Basic write then read of the same word.
        do_write(32'h0000_0100, 32'hdeadbeef);
        do_read (32'h0000_0100, 32'hdeadbeef);

        // Low address bits are ignored.
        do_write(32'h0000_0203, 32'h11111111);
        do_read (32'h0000_0200, 32'h11111111);

        // Simultaneous requests: write first, read follows after RELEASE -> IDLE (k+5).
        sb_q.push_back('{is_read: 1'b0, data: 32'h5, cyc: cyc + 1});
        sb_q.push_back('{is_read: 1'b1, data: 32'h5, cyc: cyc + 5});
        mm.main_mem_in_addr   = 32'h0000_0040;
        mm.main_mem_in_data   = 32'h0000_0005;
        mm.main_mem_in_valid  = 1'b1;
        mm.main_mem_out_addr  = 32'h0000_0040;
        mm.main_mem_out_valid = 1'b1;
        wait_ready(1'b0);
        mm.main_mem_in_valid = 1'b0;
        wait_ready(1'b1);
        mm.main_mem_out_valid = 1'b0;
        repeat (2) @(negedge clk);

        do_write(32'h0000_0000, 32'hcafef00d);

        // out_valid held for 10 cycles: exactly one pulse, duplicates trip the monitor.
        sb_q.push_back('{is_read: 1'b1, data: 32'hdeadbeef, cyc: cyc + 2});
        mm.main_mem_out_addr  = 32'h0000_0100;
        mm.main_mem_out_valid = 1'b1;
        repeat (10) @(negedge clk);
        mm.main_mem_out_valid = 1'b0;
        repeat (3) @(negedge clk);

        // Reset during READ_WAIT discards the read and clears out_data.
        mm.main_mem_out_addr  = 32'h0000_0203;
        mm.main_mem_out_valid = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        mm.main_mem_out_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_mid_out_data",  mm.main_mem_out_data,           32'd0);
        check("rst_mid_out_ready", {31'd0, mm.main_mem_out_ready}, 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_no_pulse", {31'd0, mm.main_mem_out_ready}, 32'd0);
        do_read(32'h0000_0200, 32'h11111111);

        check("bounds_err_clean", {31'd0, bounds_err}, 32'd0);

`ifdef MAIN_MEM_BOUNDS_CHECK_EN
        do_write(32'h0004_0000, 32'h12345678);
        do_read (32'h0000_0000, 32'hcafef00d);
        check("bounds_err_set", {31'd0, bounds_err}, 32'd1);
        do_read (32'h0004_0000, MEM_OOR_DATA);
        check("bounds_err_sticky", {31'd0, bounds_err}, 32'd1);
`else
        do_read (32'h0004_0000, 32'hcafef00d);
        do_write(32'h0004_0104, 32'h0badf00d);
        do_read (32'h0000_0104, 32'h0badf00d);
        check("bounds_err_tied", {31'd0, bounds_err}, 32'd0);
`endif

        repeat (5) @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
